// File: rtl/core_mem_bridge.sv
// core_mem_bridge
// Bridges a core's single-cycle data port onto an arbitrated, acknowledged bus.
// The core is stalled (core_clk_en low) while an access is in flight. A 4-bit
// watchdog bounds the wait for bus_ack and raises a sticky err on timeout.
//
// Ports
//   clk, async_rst_n      clock, asynchronous active-low reset
//   clk_en_in             global enable; low freezes all state
//   core_address/mask/wdata/mode/lock   core request (mask != 0 means request)
//   core_rdata            registered read data returned to the core
//   core_clk_en           core enable; low stalls the core
//   bus_req/bus_gnt       arbitration handshake
//   bus_addr/be/we/wdata  captured access, zero while idle
//   bus_rdata/bus_ack     completion, rdata valid with ack
//   bus_lock              locked-access indicator
//   err/err_clr           sticky timeout flag and its clear
module core_mem_bridge (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en_in,
    input  logic [29:0] core_address,
    input  logic [3:0]  core_mask,
    input  logic [31:0] core_wdata,
    input  logic        core_mode,
    input  logic        core_lock,
    output logic [31:0] core_rdata,
    output logic        core_clk_en,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_lock,
    output logic        err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic        start_s;
    logic        ack_done_s;
    logic        timeout_s;

    // Next-state decode; the event strobes already include clk_en_in.
    always_comb begin
        state_s    = state_r;
        start_s    = 1'b0;
        ack_done_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clk_en_in && (core_mask != 4'd0)) begin
                    state_s = ST_REQ;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (clk_en_in && bus_gnt) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (!clk_en_in) begin
                    state_s = ST_WAIT;
                end else if (bus_ack) begin
                    // An ack on the final watchdog cycle still completes normally.
                    state_s    = ST_DONE;
                    ack_done_s = 1'b1;
                end else if (cnt_r == 4'd14) begin
                    // This cycle brings the count to 15: fifteen WAIT cycles without ack.
                    state_s   = ST_DONE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (clk_en_in) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Core stall: released only in IDLE without a request and in DONE.
    always_comb begin
        core_clk_en = 1'b0;
        case (state_r)
            ST_IDLE: core_clk_en = clk_en_in & (core_mask == 4'd0);
            ST_DONE: core_clk_en = clk_en_in;
            default: core_clk_en = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_r <= ST_IDLE;
        end else if (clk_en_in) begin
            state_r <= state_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Bus-side registers: loaded on request, held through DONE, cleared on return to IDLE.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            bus_req   <= 1'b0;
            bus_addr  <= 30'd0;
            bus_be    <= 4'd0;
            bus_we    <= 1'b0;
            bus_wdata <= 32'd0;
            bus_lock  <= 1'b0;
        end else if (start_s) begin
            bus_req   <= 1'b1;
            bus_addr  <= core_address;
            bus_be    <= core_mask;
            bus_we    <= core_mode;
            bus_wdata <= core_wdata;
            bus_lock  <= core_lock;
        end else if (ack_done_s || timeout_s) begin
            bus_req   <= 1'b0;
        end else if (clk_en_in && (state_r == ST_DONE)) begin
            bus_req   <= 1'b0;
            bus_addr  <= 30'd0;
            bus_be    <= 4'd0;
            bus_we    <= 1'b0;
            bus_wdata <= 32'd0;
            bus_lock  <= 1'b0;
        end else begin
            bus_req   <= bus_req;
        end
    end

    // Watchdog counter: cleared on WAIT entry, counts enabled WAIT cycles without ack.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            cnt_r <= 4'd0;
        end else if (clk_en_in && (state_r == ST_REQ) && bus_gnt) begin
            cnt_r <= 4'd0;
        end else if (clk_en_in && (state_r == ST_WAIT) && !bus_ack) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Read data return; a timed-out read returns all ones. Writes leave it untouched.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            core_rdata <= 32'd0;
        end else if (ack_done_s && !bus_we) begin
            core_rdata <= bus_rdata;
        end else if (timeout_s && !bus_we) begin
            core_rdata <= 32'hFFFF_FFFF;
        end else begin
            core_rdata <= core_rdata;
        end
    end

    // Sticky error: a new timeout takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            err <= 1'b0;
        end else if (timeout_s) begin
            err <= 1'b1;
        end else if (clk_en_in && err_clr) begin
            err <= 1'b0;
        end else begin
            err <= err;
        end
    end

endmodule

// File: doc/core_mem_bridge.md
CORE_MEM_BRIDGE -- requirements
Module: core_mem_bridge

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 async_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 clk_en_in  in  1  global enable; low freezes FSM, counter, and registers.
REQ-004 core_address  in  30  word address from core data port.
REQ-005 core_mask  in  4  byte mask; nonzero = access request this cycle.
REQ-006 core_wdata  in  32  store data, little endian.
REQ-007 core_mode  in  1  1 = write, 0 = read.
REQ-008 core_lock  in  1  bus lock request from core.
REQ-009 core_rdata  out  32  read data to core writeback.
REQ-010 core_clk_en  out  1  enable to core; low stalls the core.
REQ-011 bus_req / bus_gnt  out / in  1 each  arbitration request / grant.
REQ-012 bus_addr  out  30; bus_be  out  4; bus_we  out  1; bus_wdata  out  32: captured access.
REQ-013 bus_rdata  in  32; bus_ack  in  1: completion, rdata valid with ack.
REQ-014 bus_lock  out  1  locked-access indicator.
REQ-015 err  out  1  sticky timeout flag; err_clr  in  1  clears err.

Function
REQ-016 FSM states IDLE, REQ, WAIT, DONE; advance only when clk_en_in=1.
REQ-017 IDLE: core_clk_en = clk_en_in AND (core_mask==0); request with clk_en_in=1 captures address/mask/wdata/mode/lock, goes REQ.
REQ-018 REQ: bus_req=1, bus_* drive captured values; bus_gnt=1 -> WAIT; bus_ack in REQ ignored.
REQ-019 WAIT: bus_req=1, bus_* held; bus_ack=1 -> DONE, read captures bus_rdata into core_rdata register.
REQ-020 DONE: core_clk_en = clk_en_in, bus_req=0; -> IDLE unconditionally next enabled cycle; request still on core inputs this cycle not relaunched.
REQ-021 Best-case latency: request cycle 0, gnt cycle 1, ack cycle 2, core_clk_en=1 cycle 3.
REQ-022 core_clk_en=0 in REQ and WAIT.
REQ-023 Writes: core_rdata unchanged on completion.
REQ-024 bus_lock = captured lock in REQ/WAIT/DONE, 0 in IDLE.
REQ-025 4-bit timeout counter cleared on WAIT entry, increments each enabled WAIT cycle without ack.
REQ-026 Counter reaches 15 without ack -> DONE, err=1, core_rdata=32'hFFFF_FFFF for reads.
REQ-027 Ack on same cycle as count 15: ack wins, err unchanged.
REQ-028 err_clr=1 clears err; simultaneous new timeout: set wins.
REQ-029 bus_addr/bus_be/bus_we/bus_wdata = 0 in IDLE.

Reset
REQ-030 async_rst_n low: immediately state=IDLE, bus_req=0, bus_lock=0, err=0, counter=0, core_rdata=0, bus_* =0.
REQ-031 Reset mid-transaction abandons access; no retry after release.
REQ-032 core_clk_en during reset = clk_en_in AND (core_mask==0).

Verification
REQ-033 Read addr 0x100, mask 4'hF, gnt cycle 1, ack cycle 2 rdata 0xDEADBEEF -> core_clk_en low cycles 0-2, high cycle 3, core_rdata=0xDEADBEEF.
REQ-034 Write addr 0x3, mask 4'b0011, wdata 0x1234 -> bus_we=1, bus_be=0011, bus_wdata=0x1234 during REQ/WAIT; core_rdata unchanged.
REQ-035 gnt held 5 cycles late, ack never -> 15 WAIT cycles, DONE, err=1, core_rdata=0xFFFFFFFF; err_clr pulse -> err=0.
REQ-036 clk_en_in low 3 cycles during WAIT with ack asserted -> state and counter frozen, completion on first enabled ack.
REQ-037 async_rst_n pulsed low in WAIT -> bus_req=0 same cycle, IDLE after release, err=0.
REQ-038 Locked read with core_lock=1 -> bus_lock=1 REQ through DONE, 0 in following IDLE.
